// File: rtl/compute_request_arbiter.sv
// compute_request_arbiter: round-robin arbiter sharing one compute unit among four clients,
// with issue/busy/done handshake, stale-done rejection and completion timeout.
module compute_request_arbiter #(
   parameter int DATA_W  = 32,
   parameter int RES_W   = 32,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [3:0]        cli_req,
   input  logic [7:0]        cli_type,
   input  logic [4*DATA_W-1:0] cli_data,
   output logic [3:0]        cli_gnt,
   output logic [3:0]        cli_done,
   output logic              cli_err,
   output logic [RES_W-1:0]  cli_result,
   output logic              cu_request,
   output logic [1:0]        cu_unit_id,
   output logic [1:0]        cu_comp_type,
   output logic [DATA_W-1:0] cu_data,
   input  logic              cu_ready,
   input  logic              cu_done,
   input  logic [RES_W-1:0]  cu_result
);
   localparam int CW = $clog2(TIMEOUT + 1);
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESPOND} state_t;
   state_t state, state_d;
   logic [1:0] last, last_d, sel;
   logic [CW-1:0] cnt, cnt_d;
   logic [3:0] gnt_d, done_d;
   logic err_d, req_d, expired, completion;
   logic [RES_W-1:0] result_d;
   logic [1:0] id_d, type_d;
   logic [DATA_W-1:0] data_d;
   // Scan offsets high to low so the client nearest last+1 wins.
   always_comb begin
      sel = last + 2'd1;
      for (int i = 3; i >= 0; i--)
         if (cli_req[last + 2'(i + 1)]) sel = last + 2'(i + 1);
   end
   assign expired    = cnt == CW'(TIMEOUT - 1);
   assign completion = cu_ready && cu_done;
   always_comb begin
      state_d  = state;
      last_d   = last;
      cnt_d    = cnt;
      gnt_d    = '0;
      done_d   = '0;
      err_d    = 1'b0;
      req_d    = 1'b0;
      result_d = cli_result;
      id_d     = cu_unit_id;
      type_d   = cu_comp_type;
      data_d   = cu_data;
      case (state)
         IDLE:
            if (|cli_req) begin
               state_d = ISSUE;
               gnt_d   = 4'b1 << sel;
               id_d    = sel;
               type_d  = cli_type[{sel, 1'b0} +: 2];
               data_d  = cli_data[int'(sel) * DATA_W +: DATA_W];
            end
         ISSUE:
            if (cu_ready) begin
               state_d = WAIT_BUSY;
               req_d   = 1'b1;
               cnt_d   = '0;
            end
         WAIT_BUSY, WAIT_DONE: begin
            cnt_d = cnt + 1'b1;
            // A done flag seen before the unit has gone busy is stale and ignored.
            if (state == WAIT_DONE && completion) begin
               state_d  = RESPOND;
               done_d   = 4'b1 << cu_unit_id;
               result_d = cu_result;
            end else if (expired) begin
               state_d = RESPOND;
               done_d  = 4'b1 << cu_unit_id;
               err_d   = 1'b1;
            end else if (state == WAIT_BUSY && !cu_ready) begin
               state_d = WAIT_DONE;
            end
         end
         RESPOND: begin
            state_d = IDLE;
            last_d  = cu_unit_id;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         last         <= 2'd3;
         cnt          <= '0;
         cli_gnt      <= '0;
         cli_done     <= '0;
         cli_err      <= 1'b0;
         cli_result   <= '0;
         cu_request   <= 1'b0;
         cu_unit_id   <= '0;
         cu_comp_type <= '0;
         cu_data      <= '0;
      end else begin
         state        <= state_d;
         last         <= last_d;
         cnt          <= cnt_d;
         cli_gnt      <= gnt_d;
         cli_done     <= done_d;
         cli_err      <= err_d;
         cli_result   <= result_d;
         cu_request   <= req_d;
         cu_unit_id   <= id_d;
         cu_comp_type <= type_d;
         cu_data      <= data_d;
      end
   end
endmodule

// File: tb/tb_compute_request_arbiter.sv
// tb_compute_request_arbiter: directed table plus hand sequences for the arbiter's
// round-robin, handshake, stale-done, timeout and reset behaviour.
module tb_compute_request_arbiter;
   logic clk = 1'b0, rst_n = 1'b1;
   logic [3:0] cli_req = '0, cli_gnt, cli_done;
   logic [7:0] cli_type = '0;
   logic [127:0] cli_data = '0;
   logic cli_err, cu_request, cu_ready = 1'b1, cu_done = 1'b0;
   logic [31:0] cli_result, cu_data, cu_result = '0;
   logic [1:0] cu_unit_id, cu_comp_type;
   int n_chk = 0, n_fail = 0;
   compute_request_arbiter #(.DATA_W(32), .RES_W(32), .TIMEOUT(64)) dut (
      .clk(clk), .rst_n(rst_n), .cli_req(cli_req), .cli_type(cli_type), .cli_data(cli_data),
      .cli_gnt(cli_gnt), .cli_done(cli_done), .cli_err(cli_err), .cli_result(cli_result),
      .cu_request(cu_request), .cu_unit_id(cu_unit_id), .cu_comp_type(cu_comp_type),
      .cu_data(cu_data), .cu_ready(cu_ready), .cu_done(cu_done), .cu_result(cu_result));
   always #5 clk = ~clk;
   typedef struct {
      logic [3:0]  req;
      logic [1:0]  id;
      logic [1:0]  op;
      logic [31:0] data;
      logic [31:0] res;
      int          busy;
   } vec_t;
   vec_t vecs[6];
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic setup(input logic [3:0] req, input logic [1:0] id, input logic [1:0] op,
                        input logic [31:0] d);
      for (int k = 0; k < 4; k++) begin
         cli_type[2*k +: 2]  = (k == int'(id)) ? op : ~op;
         cli_data[32*k +: 32] = (k == int'(id)) ? d : 32'hDEAD_BEE0 + k;
      end
      cli_req = req;
   endtask
   task automatic chk_reset_vals();
      chk("rst gnt", cli_gnt, 0);
      chk("rst done", cli_done, 0);
      chk("rst err", cli_err, 0);
      chk("rst result", cli_result, 0);
      chk("rst cu_request", cu_request, 0);
      chk("rst unit_id", cu_unit_id, 0);
      chk("rst comp_type", cu_comp_type, 0);
      chk("rst cu_data", cu_data, 0);
   endtask
   // Normal transaction from IDLE with cu_ready=1; ready low for busy+1 cycles.
   task automatic run_txn(input logic [1:0] id, input logic [1:0] op, input logic [31:0] d,
                          input logic [31:0] res, input int busy);
      tick();
      chk("gnt", cli_gnt, 4'b1 << id);
      chk("unit_id", cu_unit_id, id);
      chk("comp_type", cu_comp_type, op);
      chk("cu_data", cu_data, d);
      chk("no early cu_request", cu_request, 0);
      cli_data = ~cli_data;
      cli_type = ~cli_type;
      tick();
      chk("cu_request pulse", cu_request, 1);
      chk("gnt one cycle", cli_gnt, 0);
      cu_ready = 1'b0;
      cu_done  = 1'b0;
      tick();
      chk("cu_request one cycle", cu_request, 0);
      repeat (busy) begin
         tick();
         chk("done while busy", cli_done, 0);
      end
      cu_ready  = 1'b1;
      cu_done   = 1'b1;
      cu_result = res;
      tick();
      chk("done", cli_done, 4'b1 << id);
      chk("err", cli_err, 0);
      chk("result", cli_result, res);
      chk("cu_data stable", cu_data, d);
      tick();
      chk("done one cycle", cli_done, 0);
   endtask
   initial begin
      int cnt;
      vecs[0] = '{4'b0100, 2'd2, 2'd1, 32'h0000_00A5, 32'h0000_1234, 2};
      vecs[1] = '{4'b1111, 2'd3, 2'd3, 32'h3333_0003, 32'hAAAA_0001, 0};
      vecs[2] = '{4'b0011, 2'd0, 2'd0, 32'h0000_0F0F, 32'hAAAA_0002, 4};
      vecs[3] = '{4'b0101, 2'd2, 2'd2, 32'h2222_2222, 32'hAAAA_0003, 1};
      vecs[4] = '{4'b0001, 2'd0, 2'd1, 32'h1357_9BDF, 32'hAAAA_0004, 0};
      vecs[5] = '{4'b1000, 2'd3, 2'd2, 32'hFFFF_0000, 32'hAAAA_0005, 3};
      #2 rst_n = 1'b0;
      #1 chk_reset_vals();
      tick();
      tick();
      rst_n = 1'b1;
      foreach (vecs[i]) begin
         setup(vecs[i].req, vecs[i].id, vecs[i].op, vecs[i].data);
         run_txn(vecs[i].id, vecs[i].op, vecs[i].data, vecs[i].res, vecs[i].busy);
      end
      // Sticky cu_done left high from the previous operation.
      setup(4'b0010, 2'd1, 2'd3, 32'h0000_0B0B);
      cu_result = 32'hBAD;
      tick();
      chk("stale gnt", cli_gnt, 4'b0010);
      tick();
      chk("stale cu_request", cu_request, 1);
      cnt = 0;
      repeat (3) begin
         tick();
         cnt += int'(cli_done != 0);
      end
      cu_ready = 1'b0;
      repeat (2) begin
         tick();
         cnt += int'(cli_done != 0);
      end
      chk("stale done ignored", cnt, 0);
      chk("stale result untouched", cli_result, 32'hAAAA_0005);
      cu_ready  = 1'b1;
      cu_result = 32'hB0B0_0001;
      tick();
      chk("stale then done", cli_done, 4'b0010);
      chk("stale then result", cli_result, 32'hB0B0_0001);
      tick();
      // Timeout: ready never returns.
      setup(4'b0001, 2'd0, 2'd0, 32'h77);
      tick();
      tick();
      cu_ready  = 1'b0;
      cu_done   = 1'b0;
      cu_result = 32'hBAD;
      cnt = 0;
      repeat (63) begin
         tick();
         cnt += int'(cli_done != 0);
      end
      chk("no early timeout", cnt, 0);
      tick();
      chk("timeout done", cli_done, 4'b0001);
      chk("timeout err", cli_err, 1);
      chk("timeout result kept", cli_result, 32'hB0B0_0001);
      tick();
      chk("timeout done one cycle", cli_done, 0);
      chk("timeout err one cycle", cli_err, 0);
      // Completion on the last cycle before timeout wins.
      cu_ready = 1'b1;
      setup(4'b1001, 2'd3, 2'd1, 32'h99);
      tick();
      chk("race gnt", cli_gnt, 4'b1000);
      tick();
      cu_ready = 1'b0;
      repeat (63) tick();
      cu_ready  = 1'b1;
      cu_done   = 1'b1;
      cu_result = 32'hC0C0;
      tick();
      chk("race done", cli_done, 4'b1000);
      chk("race err", cli_err, 0);
      chk("race result", cli_result, 32'hC0C0);
      tick();
      // cu_ready low throughout ISSUE.
      cu_ready = 1'b0;
      cu_done  = 1'b0;
      setup(4'b0100, 2'd2, 2'd2, 32'h55);
      tick();
      chk("issue-wait gnt", cli_gnt, 4'b0100);
      cnt = 0;
      repeat (10) begin
         tick();
         cnt += int'(cu_request != 0) + int'(cli_done != 0);
      end
      chk("issue held", cnt, 0);
      cu_ready = 1'b1;
      tick();
      chk("issue after ready", cu_request, 1);
      cu_ready = 1'b0;
      tick();
      cu_ready  = 1'b1;
      cu_done   = 1'b1;
      cu_result = 32'hD00D;
      tick();
      chk("issue-wait done", cli_done, 4'b0100);
      chk("issue-wait err", cli_err, 0);
      chk("issue-wait result", cli_result, 32'hD00D);
      tick();
      // Reset while waiting for completion.
      cu_done = 1'b0;
      setup(4'b0001, 2'd0, 2'd0, 32'h11);
      tick();
      tick();
      cu_ready = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      #1 chk_reset_vals();
      tick();
      chk("no done in reset", cli_done, 0);
      rst_n    = 1'b1;
      cu_ready = 1'b1;
      cu_done  = 1'b1;
      for (int j = 0; j < 5; j++) begin
         setup(4'hF, 2'(j), 2'(j + 1), 32'h100 + j);
         run_txn(2'(j), 2'(j + 1), 32'h100 + j, 32'h5000 + j, 1);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/compute_request_arbiter.md
COMPUTE_REQUEST_ARBITER -- requirements
Module: compute_request_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning width of one flattened operand payload per client.
REQ-002 SHALL have parameter RES_W, default 32, meaning width of the compute result.
REQ-003 SHALL have parameter TIMEOUT, default 64, meaning maximum cycles waited for completion after issue.
REQ-004 SHALL have port clk, input, 1, clock (rising-edge).
REQ-005 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have port cli_req, input, 4, per-client request level, held until that client's cli_gnt.
REQ-007 SHALL have port cli_type, input, 8, per-client 2-bit op code (client k = bits [2k+1:2k]; 0 ADD, 1 MUL, 2 TANH, 3 RELU).
REQ-008 SHALL have port cli_data, input, 4*DATA_W, per-client operand (client k = slice k).
REQ-009 SHALL have port cli_gnt, output, 4, one-hot one-cycle pulse when a client's request is latched.
REQ-010 SHALL have port cli_done, output, 4, one-hot one-cycle completion pulse to the granted client.
REQ-011 SHALL have port cli_err, output, 1, qualifies cli_done; 1 = timeout, result invalid.
REQ-012 SHALL have port cli_result, output, RES_W, result, valid while any cli_done bit is high.
REQ-013 SHALL have port cu_request, output, 1, request to the shared compute unit.
REQ-014 SHALL have port cu_unit_id, output, 2, index of the granted client.
REQ-015 SHALL have port cu_comp_type, output, 2, latched op code.
REQ-016 SHALL have port cu_data, output, DATA_W, latched operand.
REQ-017 SHALL have port cu_ready, input, 1, compute unit idle/accepting.
REQ-018 SHALL have port cu_done, input, 1, compute unit completion flag; sticky (may stay high between operations).
REQ-019 SHALL have port cu_result, input, RES_W, compute unit result.

Function
REQ-020 SHALL implement states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESPOND; all outputs registered.
REQ-021 IDLE: if cli_req != 0, SHALL select the first requesting client in round-robin order starting at last_grant+1 (mod 4), latch its index/type/data onto cu_unit_id/cu_comp_type/cu_data, pulse cli_gnt for that client in the next cycle, go ISSUE.
REQ-022 ISSUE: when cu_ready=1, SHALL assert cu_request for exactly one cycle and go WAIT_BUSY; while cu_ready=0, SHALL remain in ISSUE with cu_request=0 (no timeout counting).
REQ-023 WAIT_BUSY: on cu_ready=0 SHALL go WAIT_DONE; cu_done is ignored here (stale sticky flag never counts as completion).
REQ-024 WAIT_DONE: on cu_ready=1 and cu_done=1 in the same cycle SHALL capture cu_result into cli_result and go RESPOND.
REQ-025 RESPOND: SHALL pulse cli_done[grant] for one cycle with cli_err=0, set last_grant=grant, return to IDLE.
REQ-026 Timeout counter SHALL clear on entering WAIT_BUSY, increment each cycle in WAIT_BUSY/WAIT_DONE; on reaching TIMEOUT SHALL pulse cli_done[grant] with cli_err=1, leave cli_result unchanged, set last_grant=grant, return to IDLE.
REQ-027 Completion and timeout in the same cycle: completion SHALL win (cli_err=0).
REQ-028 cu_unit_id/cu_comp_type/cu_data SHALL stay stable from ISSUE until return to IDLE; cli_req/cli_data changes after grant SHALL be ignored.
REQ-029 Requests arriving outside IDLE SHALL wait; no request is dropped while cli_req is held.
REQ-030 Minimum latency: cli_req seen at cycle 0 with cu_ready=1 -> cli_gnt and state ISSUE at cycle 1, cu_request at cycle 2.

Reset
REQ-031 On rst_n=0 SHALL immediately force state IDLE, last_grant=3 (client 0 first), cli_gnt=0, cli_done=0, cli_err=0, cli_result=0, cu_request=0, cu_unit_id=0, cu_comp_type=0, cu_data=0, timeout counter=0.
REQ-032 Reset mid-operation SHALL abandon the transaction with no cli_done pulse; after release behaviour SHALL match a fresh start.

Verification
REQ-033 Single client 2 (type MUL, data 0x0000_00A5), model responds ready low 3 cycles then ready=1/done=1, result 0x1234 -> cu_unit_id=2, one cu_request pulse, cli_done=4'b0100, cli_err=0, cli_result=0x1234.
REQ-034 cli_req=4'b1111 held after reset -> grant order 0,1,2,3,0; each client gets exactly one cli_done per grant.
REQ-035 cu_done stuck at 1 from a prior operation, new issue -> no completion until cu_ready has gone low then high; result captured only then.
REQ-036 Model never reasserts cu_ready with TIMEOUT=64 -> cli_done[grant]=1, cli_err=1 exactly 64 cycles after entering WAIT_BUSY, cli_result unchanged.
REQ-037 cu_ready=0 during ISSUE for 10 cycles -> cu_request stays 0, no timeout; request issued in the cycle after cu_ready rises.
REQ-038 rst_n asserted during WAIT_DONE -> all outputs at reset values immediately, no cli_done; next request served normally.
